hc_read_sched: RTL and testbench

Round-robin scheduler that shares the single buffer read-stream command channel between NUM_REQ accelerator requesters. It grants one requester at a time and issues a (buffer index, line count) stream command. It then holds the channel until the stream's last response line returns, and pulses a per-requester done. It sits between the accelerator engines and the buffer read interface, in front of the read_stream/read_idle command path.

---
 rtl/hc_read_sched_if.sv | 29 ++
 rtl/hc_read_sched.sv | 158 +++++++++++++++
 tb/tb_hc_read_sched.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hc_read_sched_if.sv
// Request, command and response bundle shared by the accelerator requesters,
// the read scheduler and the buffer read-stream channel.
interface hc_read_sched_if #(
  parameter int NUM_REQ   = 4,
  parameter int BUF_IDX_W = 4,
  parameter int SIZE_W    = 16
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*BUF_IDX_W-1:0] req_buf;
  logic [NUM_REQ*SIZE_W-1:0]    req_size;
  logic [NUM_REQ-1:0]           req_ack;
  logic [NUM_REQ-1:0]           req_done;
  logic                         cmd_valid;
  logic [BUF_IDX_W-1:0]         cmd_buf;
  logic [SIZE_W-1:0]            cmd_size;
  logic                         cmd_ready;
  logic                         rsp_valid;
  logic                         rsp_last;

  // master: the scheduler; slave: requesters plus read channel
  modport master (
    input  req_valid, req_buf, req_size, cmd_ready, rsp_valid, rsp_last,
    output req_ack, req_done, cmd_valid, cmd_buf, cmd_size
  );
  modport slave (
    output req_valid, req_buf, req_size, cmd_ready, rsp_valid, rsp_last,
    input  req_ack, req_done, cmd_valid, cmd_buf, cmd_size
  );
endinterface

// File: rtl/hc_read_sched.sv
// Round-robin owner of the single buffer read-stream command channel.
// Optional HC_READ_SCHED_WDOG_EN adds a WAIT-state watchdog that aborts silent streams.
module hc_read_sched #(
  parameter int NUM_REQ   = 4,
  parameter int BUF_IDX_W = 4,
  parameter int SIZE_W    = 16,
  parameter int WDOG_W    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  hc_read_sched_if.master            bus,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] cur_owner,
  output logic                       err
);
  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t               r_state;
  logic [PTR_W-1:0]     r_rr_ptr;
  logic [PTR_W-1:0]     r_owner;
  logic [NUM_REQ-1:0]   r_req_ack;
  logic [NUM_REQ-1:0]   r_req_done;
  logic                 r_cmd_valid;
  logic [BUF_IDX_W-1:0] r_cmd_buf;
  logic [SIZE_W-1:0]    r_cmd_size;
  logic [SIZE_W-1:0]    r_cnt;
  logic                 r_err;

  logic [BUF_IDX_W-1:0] w_bufs  [NUM_REQ];
  logic [SIZE_W-1:0]    w_sizes [NUM_REQ];
  logic [NUM_REQ-1:0]   w_rot;
  logic                 w_found;
  logic [PTR_W-1:0]     w_off;
  logic [PTR_W:0]       w_sum;
  logic [PTR_W-1:0]     w_pick;
  logic [PTR_W-1:0]     w_pick_next;
  logic [NUM_REQ-1:0]   w_pick_oh;
  logic [NUM_REQ-1:0]   w_owner_oh;
  logic                 w_wdog_expired;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_bufs[gi]  = bus.req_buf[gi*BUF_IDX_W +: BUF_IDX_W];
    assign w_sizes[gi] = bus.req_size[gi*SIZE_W +: SIZE_W];
  end

  // Rotate so bit 0 is the requester at rr_ptr; the lowest set bit is the winner.
  assign w_rot = NUM_REQ'({bus.req_valid, bus.req_valid} >> r_rr_ptr);

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_found = 1'b1;
        w_off   = PTR_W'(k);
      end
    end
  end

  assign w_sum       = {1'b0, r_rr_ptr} + {1'b0, w_off};
  assign w_pick      = (w_sum >= (PTR_W+1)'(NUM_REQ)) ? PTR_W'(w_sum - (PTR_W+1)'(NUM_REQ))
                                                      : PTR_W'(w_sum);
  assign w_pick_next = (w_pick == PTR_W'(NUM_REQ - 1)) ? '0 : w_pick + 1'b1;
  assign w_pick_oh   = NUM_REQ'(1) << w_pick;
  assign w_owner_oh  = NUM_REQ'(1) << r_owner;

`ifdef HC_READ_SCHED_WDOG_EN
  logic [WDOG_W-1:0] r_wdog;

  always_ff @(posedge clk) begin
    if (reset || r_state != WAIT || bus.rsp_valid) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + 1'b1;
    end
  end

  assign w_wdog_expired = &r_wdog;
`else
  assign w_wdog_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_req_ack   <= '0;
      r_req_done  <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_buf   <= '0;
      r_cmd_size  <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
    end else begin
      r_req_ack <= '0;
      case (r_state)
        IDLE: begin
          if (bus.rsp_valid) r_err <= 1'b1;
          if (enable && w_found) begin
            r_owner    <= w_pick;
            r_rr_ptr   <= w_pick_next;
            r_req_ack  <= w_pick_oh;
            r_cmd_buf  <= w_bufs[w_pick];
            r_cmd_size <= w_sizes[w_pick];
            r_state    <= (w_sizes[w_pick] == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          // A response here (including the acceptance cycle) cannot belong to this stream.
          if (bus.rsp_valid) r_err <= 1'b1;
          if (!r_cmd_valid) begin
            r_cmd_valid <= 1'b1;
          end else if (bus.cmd_ready) begin
            r_cmd_valid <= 1'b0;
            r_cnt       <= r_cmd_size;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          if (bus.rsp_valid) begin
            r_cnt <= r_cnt - SIZE_W'(1);
            if (bus.rsp_last || r_cnt == SIZE_W'(1)) begin
              if (!(bus.rsp_last && r_cnt == SIZE_W'(1))) r_err <= 1'b1;
              r_req_done <= w_owner_oh;
              r_state    <= DONE;
            end
          end else if (w_wdog_expired) begin
            r_err      <= 1'b1;
            r_req_done <= w_owner_oh;
            r_state    <= DONE;
          end
        end
        default: begin
          // Zero-length grants arrive without a done pulse; emit it before leaving.
          if (r_req_done == '0) begin
            r_req_done <= w_owner_oh;
          end else begin
            r_req_done <= '0;
            r_state    <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.req_ack   = r_req_ack;
  assign bus.req_done  = r_req_done;
  assign bus.cmd_valid = r_cmd_valid;
  assign bus.cmd_buf   = r_cmd_buf;
  assign bus.cmd_size  = r_cmd_size;
  assign busy          = (r_state != IDLE);
  assign cur_owner     = r_owner;
  assign err           = r_err;
endmodule

// File: tb/tb_hc_read_sched.sv
// Scoreboard bench for hc_read_sched: batches of held requests are turned into
// expected grant/command/done events by a round-robin model; a monitor pops and compares.
`timescale 1ns/1ps
module tb_hc_read_sched;
  localparam int NUM_REQ   = 4;
  localparam int BUF_IDX_W = 4;
  localparam int SIZE_W    = 16;
`ifdef HC_READ_SCHED_WDOG_EN
  localparam int WDOG_W = 4;
`else
  localparam int WDOG_W = 16;
`endif

  typedef struct {int owner; int bufi; int size; int kind; int err;} exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       busy;
  logic [1:0] cur_owner;
  logic       err;

  hc_read_sched_if #(.NUM_REQ(NUM_REQ), .BUF_IDX_W(BUF_IDX_W), .SIZE_W(SIZE_W)) sif ();

  hc_read_sched #(.NUM_REQ(NUM_REQ), .BUF_IDX_W(BUF_IDX_W), .SIZE_W(SIZE_W), .WDOG_W(WDOG_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .bus(sif),
    .busy(busy), .cur_owner(cur_owner), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  exp_t q_ack[$];
  exp_t q_cmd[$];
  exp_t q_done[$];
  int m_ptr = 0;
  int m_err = 0;
  bit wdog_mode = 0;
  int bbuf[NUM_REQ];
  int bsz[NUM_REQ];
  int raise_cyc = 0;

  int ready_prob = 100, rsp_prob = 100, hold_cnt = 0, inj_last_at = 0, rsp_limit = -1;
  bit stray = 0;
  int rs_left = 0, rs_sent = 0, last_rsp_last_cyc = -1;
  int last_ack_cyc = -1, last_rise_cyc = -1, last_accept_cyc = -1;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input longint act);
    total++;
    bad++;
    $display("FAIL %s: got %0d expected no event (cycle %0d)", name, act, cyc);
  endtask

  // Read channel: optional backpressure, randomly spaced responses, error injection.
  initial begin : responder
    sif.cmd_ready = 1'b0;
    sif.rsp_valid = 1'b0;
    sif.rsp_last  = 1'b0;
    forever begin
      @(negedge clk);
      sif.rsp_valid = 1'b0;
      sif.rsp_last  = 1'b0;
      if (reset) begin
        rs_left = 0;
        stray = 0;
        sif.cmd_ready = 1'b0;
      end else begin
        if (stray) begin
          sif.rsp_valid = 1'b1;
          stray = 0;
        end else if (rs_left > 0 && rs_sent != rsp_limit && $urandom_range(99) < rsp_prob) begin
          rs_sent++;
          rs_left--;
          sif.rsp_valid = 1'b1;
          if (rs_sent == inj_last_at || rs_left == 0) begin
            sif.rsp_last = 1'b1;
            rs_left = 0;
            last_rsp_last_cyc = cyc;
          end
        end
        if (sif.cmd_valid && hold_cnt > 0) begin
          sif.cmd_ready = 1'b0;
          hold_cnt--;
        end else begin
          sif.cmd_ready = ($urandom_range(99) < ready_prob);
        end
        if (sif.cmd_valid && sif.cmd_ready) begin
          rs_left = int'(sif.cmd_size);
          rs_sent = 0;
        end
      end
    end
  end

  initial begin : monitor
    bit prev_hold, prev_done, prev_cmdv;
    logic [BUF_IDX_W-1:0] prev_buf;
    logic [SIZE_W-1:0] prev_size;
    exp_t e;
    prev_hold = 0; prev_done = 0; prev_cmdv = 0; prev_buf = '0; prev_size = '0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        prev_hold = 0; prev_done = 0; prev_cmdv = 0;
      end else begin
        if (prev_hold) begin
          check("cmd_hold_valid", sif.cmd_valid, 1);
          check("cmd_hold_buf", sif.cmd_buf, prev_buf);
          check("cmd_hold_size", sif.cmd_size, prev_size);
        end
        if (prev_done) check("busy_after_done", busy, 0);
        if (sif.cmd_valid && !prev_cmdv) begin
          check("cmd_rise_after_ack", cyc, last_ack_cyc + 1);
          last_rise_cyc = cyc;
        end
        if (sif.req_ack != '0) begin
          if (q_ack.size() == 0) fail_now("ack_unexpected", sif.req_ack);
          else begin
            e = q_ack.pop_front();
            check("ack_vec", sif.req_ack, 1 << e.owner);
            check("ack_owner", cur_owner, e.owner);
          end
          last_ack_cyc = cyc;
          sif.req_valid = sif.req_valid & ~sif.req_ack;
        end
        if (sif.cmd_valid && sif.cmd_ready) begin
          if (q_cmd.size() == 0) fail_now("cmd_unexpected", sif.cmd_size);
          else begin
            e = q_cmd.pop_front();
            check("cmd_buf", sif.cmd_buf, e.bufi);
            check("cmd_size", sif.cmd_size, e.size);
          end
          last_accept_cyc = cyc;
        end
        if (sif.req_done != '0) begin
          if (q_done.size() == 0) fail_now("done_unexpected", sif.req_done);
          else begin
            e = q_done.pop_front();
            check("done_vec", sif.req_done, 1 << e.owner);
            check("done_err", err, e.err);
            check("done_busy", busy, 1);
            if (e.kind == 0) check("done_latency", cyc, last_rsp_last_cyc + 1);
            if (e.kind == 1) check("zero_done_latency", cyc, last_ack_cyc + 1);
            $display("txn owner=%0d buf=%0d size=%0d err=%0d cycle=%0d", e.owner, e.bufi, e.size, err, cyc);
          end
        end
        prev_hold = sif.cmd_valid && !sif.cmd_ready;
        prev_buf  = sif.cmd_buf;
        prev_size = sif.cmd_size;
        prev_done = (sif.req_done != '0);
        prev_cmdv = sif.cmd_valid;
      end
    end
  end

  task automatic set_req(input int i, input int b, input int s);
    bbuf[i] = b;
    bsz[i]  = s;
  endtask

  // Model: all requesters in mask are held from the same cycle, so they are
  // served in cyclic order starting at the pointer, each exactly once.
  task automatic issue_batch(input int mask);
    int pend, o;
    exp_t e;
    pend = mask;
    while (pend != 0) begin
      o = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NUM_REQ;
        if (o < 0 && ((pend >> idx) & 1) == 1) o = idx;
      end
      e.owner = o; e.bufi = bbuf[o]; e.size = bsz[o]; e.err = m_err;
      e.kind = wdog_mode ? 2 : ((bsz[o] == 0) ? 1 : 0);
      q_ack.push_back(e);
      if (e.size != 0) q_cmd.push_back(e);
      q_done.push_back(e);
      pend = pend & ~(1 << o);
      m_ptr = (o + 1) % NUM_REQ;
    end
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++) begin
      sif.req_buf[i*BUF_IDX_W +: BUF_IDX_W] = BUF_IDX_W'(bbuf[i]);
      sif.req_size[i*SIZE_W +: SIZE_W]      = SIZE_W'(bsz[i]);
    end
    sif.req_valid = NUM_REQ'(mask);
    raise_cyc = cyc;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((q_done.size() != 0 || sif.req_valid != '0) && n < 3000) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (n >= 3000) fail_now({name, "_timeout"}, q_done.size());
    repeat (2) @(negedge clk);
    #3;
    check({name, "_idle"}, busy, 0);
    check({name, "_cmd_q"}, q_cmd.size(), 0);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    reset = 1'b1;
    sif.req_valid = '0;
    @(negedge clk);
    #2;
    check({name, "_cmd_valid"}, sif.cmd_valid, 0);
    check({name, "_cmd_buf"}, sif.cmd_buf, 0);
    check({name, "_cmd_size"}, sif.cmd_size, 0);
    check({name, "_ack"}, sif.req_ack, 0);
    check({name, "_done"}, sif.req_done, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_owner"}, cur_owner, 0);
    check({name, "_err"}, err, 0);
    reset = 1'b0;
    m_ptr = 0;
    m_err = 0;
    q_ack.delete();
    q_cmd.delete();
    q_done.delete();
  endtask

  initial begin : main
    int n;
    reset = 1'b1;
    enable = 1'b1;
    sif.req_valid = '0;
    sif.req_buf = '0;
    sif.req_size = '0;
    repeat (2) @(negedge clk);
    do_reset("reset");

    set_req(0, 3, 10);
    issue_batch(1);
    wait_drain("single");
    check("single_ack_latency", last_ack_cyc, raise_cyc + 1);
    check("single_err", err, 0);

    for (int i = 0; i < NUM_REQ; i++) set_req(i, i + 5, 2);
    issue_batch(15);
    wait_drain("rr_all");
    set_req(0, 9, 2);
    issue_batch(1);
    wait_drain("rr_wrap");

    hold_cnt = 5;
    set_req(1, 7, 3);
    issue_batch(2);
    wait_drain("backpressure");
    check("bp_accept_cycle", last_accept_cyc - last_rise_cyc, 5);

    set_req(2, 4, 0);
    issue_batch(4);
    wait_drain("zero_len");

    enable = 1'b0;
    set_req(3, 1, 3);
    issue_batch(8);
    repeat (6) @(negedge clk);
    #3;
    check("disabled_busy", busy, 0);
    check("disabled_pending_ack", q_ack.size(), 1);
    enable = 1'b1;
    wait_drain("enable");

    ready_prob = 70;
    rsp_prob = 75;
    repeat (40) begin
      for (int i = 0; i < NUM_REQ; i++) set_req(i, int'($urandom_range(15)), int'($urandom_range(5)));
      issue_batch(int'($urandom_range(15, 1)));
      wait_drain("rand");
    end
    ready_prob = 100;
    rsp_prob = 100;

    m_err = 1;
    inj_last_at = 2;
    set_req(1, 2, 4);
    issue_batch(2);
    wait_drain("early_last");
    inj_last_at = 0;
    check("early_last_err", err, 1);
    set_req(3, 6, 3);
    issue_batch(8);
    wait_drain("after_err");
    check("err_sticky", err, 1);
    do_reset("err_clear");

    @(negedge clk);
    stray = 1;
    repeat (3) @(negedge clk);
    #3;
    check("stray_rsp_err", err, 1);
    do_reset("stray_clear");

    rsp_limit = 3;
    set_req(1, 6, 8);
    issue_batch(2);
    n = 0;
    while (rs_sent != 3 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("midwait_rsp_count", rs_sent, 3);
    repeat (2) @(negedge clk);
    #3;
    check("midwait_busy", busy, 1);
    do_reset("midwait");
    rsp_limit = -1;
    repeat (5) @(negedge clk);
    set_req(2, 5, 3);
    issue_batch(4);
    wait_drain("after_midwait");
    check("after_midwait_err", err, 0);

`ifdef HC_READ_SCHED_WDOG_EN
    rsp_limit = 0;
    m_err = 1;
    wdog_mode = 1;
    set_req(0, 1, 4);
    issue_batch(1);
    wait_drain("wdog");
    check("wdog_err", err, 1);
    wdog_mode = 0;
    do_reset("wdog_clear");
    rsp_limit = -1;
`endif

    check("ack_q_empty", q_ack.size(), 0);
    check("done_q_empty", q_done.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
